// File: rtl/scan_sched_if.sv
// Bundle between the HCI scan registers / correlators and the scan scheduler.
// The scheduler side uses the slave modport; stimulus or upstream logic uses master.
interface scan_sched_if #(
  parameter int CNTW = 16
);
  logic            tslot_p;
  logic [CNTW-1:0] regi_Tpsinterval;
  logic [CNTW-1:0] regi_Tpswindow;
  logic [CNTW-1:0] regi_Tisinterval;
  logic [CNTW-1:0] regi_Tiswindow;
  logic            PageScanEnable;
  logic            InqScanEnable;
  logic            ps_hit;
  logic            is_hit;
  logic            resp_done;
  logic [3:0]      regi_respTO;
  logic            ps_grant;
  logic            is_grant;
  logic            resp_busy;
  logic            respTO;
  logic [2:0]      dbg_state;

  modport master (
    output tslot_p, regi_Tpsinterval, regi_Tpswindow, regi_Tisinterval, regi_Tiswindow,
    output PageScanEnable, InqScanEnable, ps_hit, is_hit, resp_done, regi_respTO,
    input  ps_grant, is_grant, resp_busy, respTO, dbg_state
  );

  modport slave (
    input  tslot_p, regi_Tpsinterval, regi_Tpswindow, regi_Tisinterval, regi_Tiswindow,
    input  PageScanEnable, InqScanEnable, ps_hit, is_hit, resp_done, regi_respTO,
    output ps_grant, is_grant, resp_busy, respTO, dbg_state
  );
endinterface

// File: rtl/scan_sched.sv
// Shares one receive front-end between page scan and inquiry scan windows,
// holding the grant through the response substate after a correlator hit.
module scan_sched #(
  parameter int CNTW = 16
) (
  input  logic         clk_6M,
  input  logic         rst,
  scan_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PS      = 3'd1,
    ST_IS      = 3'd2,
    ST_RESP_PS = 3'd3,
    ST_RESP_IS = 3'd4
  } state_t;

  state_t          r_state;
  logic [CNTW-1:0] r_pscnt;
  logic [CNTW-1:0] r_iscnt;
  logic [3:0]      r_tocnt;
  logic            r_last_is;
  logic            r_seen;
  logic            r_ps_grant;
  logic            r_is_grant;
  logic            r_resp_busy;
  logic            r_resp_to;

  logic            w_ps_req;
  logic            w_is_req;
  logic            w_in_resp;
  logic [3:0]      w_to_lim;
  logic [3:0]      w_to_inc;
  logic            w_to_fire;
  state_t          w_arb;
  state_t          w_next;

  // Slot counters run regardless of scheduler state; interval 0 pins them at 0.
  always_ff @(posedge clk_6M) begin
    if (rst || !bus.PageScanEnable) begin
      r_pscnt <= '0;
    end else if (bus.tslot_p) begin
      if (bus.regi_Tpsinterval == '0 || r_pscnt >= bus.regi_Tpsinterval - CNTW'(1))
        r_pscnt <= '0;
      else
        r_pscnt <= r_pscnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst || !bus.InqScanEnable) begin
      r_iscnt <= '0;
    end else if (bus.tslot_p) begin
      if (bus.regi_Tisinterval == '0 || r_iscnt >= bus.regi_Tisinterval - CNTW'(1))
        r_iscnt <= '0;
      else
        r_iscnt <= r_iscnt + CNTW'(1);
    end
  end

  always_comb begin
    w_ps_req  = bus.PageScanEnable && (r_pscnt < bus.regi_Tpswindow);
    w_is_req  = bus.InqScanEnable && (r_iscnt < bus.regi_Tiswindow);
    w_in_resp = (r_state == ST_RESP_PS) || (r_state == ST_RESP_IS);
    w_to_lim  = (bus.regi_respTO == 4'd0) ? 4'd8 : bus.regi_respTO;
    w_to_inc  = r_tocnt + 4'd1;

    // Owner keeps the front-end while requesting; ties alternate, PS first after reset.
    w_arb = ST_IDLE;
    if (r_state == ST_PS && w_ps_req)
      w_arb = ST_PS;
    else if (r_state == ST_IS && w_is_req)
      w_arb = ST_IS;
    else if (w_ps_req && w_is_req)
      w_arb = (r_seen && !r_last_is) ? ST_IS : ST_PS;
    else if (w_ps_req)
      w_arb = ST_PS;
    else if (w_is_req)
      w_arb = ST_IS;

    w_next    = r_state;
    w_to_fire = 1'b0;
    case (r_state)
      ST_IDLE, ST_PS, ST_IS: begin
        if (r_state == ST_PS && !bus.PageScanEnable)
          w_next = ST_IDLE;
        else if (r_state == ST_IS && !bus.InqScanEnable)
          w_next = ST_IDLE;
        else if (r_state == ST_PS && bus.ps_hit)
          w_next = ST_RESP_PS;
        else if (r_state == ST_IS && bus.is_hit)
          w_next = ST_RESP_IS;
        else if (bus.tslot_p)
          w_next = w_arb;
      end
      ST_RESP_PS, ST_RESP_IS: begin
        if (bus.resp_done) begin
          w_next = ST_IDLE;
        end else if (bus.tslot_p && w_to_inc == w_to_lim) begin
          w_next    = ST_IDLE;
          w_to_fire = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tocnt     <= 4'd0;
      r_last_is   <= 1'b0;
      r_seen      <= 1'b0;
      r_ps_grant  <= 1'b0;
      r_is_grant  <= 1'b0;
      r_resp_busy <= 1'b0;
      r_resp_to   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ps_grant  <= (w_next == ST_PS) || (w_next == ST_RESP_PS);
      r_is_grant  <= (w_next == ST_IS) || (w_next == ST_RESP_IS);
      r_resp_busy <= (w_next == ST_RESP_PS) || (w_next == ST_RESP_IS);
      r_resp_to   <= w_to_fire;
      if (!w_in_resp)
        r_tocnt <= 4'd0;
      else if (bus.tslot_p)
        r_tocnt <= w_to_inc;
      if (w_next == ST_PS && r_state != ST_PS) begin
        r_last_is <= 1'b0;
        r_seen    <= 1'b1;
      end else if (w_next == ST_IS && r_state != ST_IS) begin
        r_last_is <= 1'b1;
        r_seen    <= 1'b1;
      end
    end
  end

  assign bus.ps_grant  = r_ps_grant;
  assign bus.is_grant  = r_is_grant;
  assign bus.resp_busy = r_resp_busy;
  assign bus.respTO    = r_resp_to;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_scan_sched.sv
// Randomized and directed stimulus for scan_sched, checked cycle by cycle
// against a slot-level reference model through an expected-value queue.
module tb_scan_sched;

  localparam int SLOT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_sched_if #(.CNTW(16)) bus ();

  scan_sched #(.CNTW(16)) dut (
    .clk_6M (clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  // stimulus state
  logic  s_rst, s_pse, s_ise, s_ps_hit, s_is_hit, s_done;
  int    s_psi, s_psw, s_isi, s_isw, s_rto;
  int    cyc;
  string phase;

  // reference model: owner 0 none / 1 page / 2 inquiry, plus response flag
  int m_owner, m_resp, m_to, m_last, m_pscnt, m_iscnt;

  logic [3:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic model_step(input logic tslot, output logic [3:0] e);
    bit ps_req, is_req, to_pulse;
    int winner, nps, nis;
    to_pulse = 0;
    if (s_rst) begin
      m_owner = 0; m_resp = 0; m_to = 0; m_last = 0; m_pscnt = 0; m_iscnt = 0;
      e = 4'b0000;
    end else begin
      ps_req = s_pse && (m_pscnt < s_psw);
      is_req = s_ise && (m_iscnt < s_isw);
      if (m_resp != 0) begin
        if (s_done) begin
          m_resp = 0; m_owner = 0;
        end else if (tslot) begin
          m_to++;
          if (m_to == ((s_rto == 0) ? 8 : s_rto)) begin
            m_resp = 0; m_owner = 0; to_pulse = 1;
          end
        end
      end else if (m_owner == 1 && !s_pse) begin
        m_owner = 0;
      end else if (m_owner == 2 && !s_ise) begin
        m_owner = 0;
      end else if ((m_owner == 1 && s_ps_hit) || (m_owner == 2 && s_is_hit)) begin
        m_resp = 1; m_to = 0;
      end else if (tslot) begin
        if (m_owner == 1 && ps_req)      winner = 1;
        else if (m_owner == 2 && is_req) winner = 2;
        else if (ps_req && is_req)       winner = (m_last == 1) ? 2 : 1;
        else if (ps_req)                 winner = 1;
        else if (is_req)                 winner = 2;
        else                             winner = 0;
        if (winner != 0 && winner != m_owner) m_last = winner;
        m_owner = winner;
      end
      nps = !s_pse ? 0 : (!tslot ? m_pscnt : ((m_pscnt + 1 >= s_psi) ? 0 : m_pscnt + 1));
      nis = !s_ise ? 0 : (!tslot ? m_iscnt : ((m_iscnt + 1 >= s_isi) ? 0 : m_iscnt + 1));
      m_pscnt = nps;
      m_iscnt = nis;
      e = {m_owner == 1, m_owner == 2, m_resp != 0, to_pulse};
    end
  endtask

  task automatic drive(input logic tslot);
    rst                  = s_rst;
    bus.tslot_p          = tslot;
    bus.regi_Tpsinterval = 16'(s_psi);
    bus.regi_Tpswindow   = 16'(s_psw);
    bus.regi_Tisinterval = 16'(s_isi);
    bus.regi_Tiswindow   = 16'(s_isw);
    bus.PageScanEnable   = s_pse;
    bus.InqScanEnable    = s_ise;
    bus.ps_hit           = s_ps_hit;
    bus.is_hit           = s_is_hit;
    bus.resp_done        = s_done;
    bus.regi_respTO      = 4'(s_rto);
  endtask

  // one clock: apply inputs, predict the post-edge outputs, clear one-shot pulses
  task automatic tick();
    logic ts;
    logic [3:0] e;
    @(negedge clk);
    ts = ((cyc % SLOT) == SLOT - 1);
    drive(ts);
    model_step(ts, e);
    exp_q.push_back(e);
    cyc++;
    s_ps_hit = 0; s_is_hit = 0; s_done = 0;
  endtask

  task automatic run_slots(input int n);
    repeat (n * SLOT) tick();
  endtask

  task automatic do_reset();
    s_rst = 1; tick(); tick(); s_rst = 0;
  endtask

  task automatic wait_grant(input int who, input string what);
    int k = 0;
    while (!(m_owner == who && m_resp == 0) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_%s got=timeout want=grant within 200 cycles", what);
    end
  endtask

  // monitor: compare {ps_grant,is_grant,resp_busy,respTO} after each edge
  always @(posedge clk) begin
    logic [3:0] got, want;
    #1;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      got  = {bus.ps_grant, bus.is_grant, bus.resp_busy, bus.respTO};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%b want=%b (ps,is,busy,to)", phase, cyc, got, want);
      end
    end
  end

  initial begin
    cyc = 0;
    s_rst = 1; s_pse = 0; s_ise = 0; s_ps_hit = 0; s_is_hit = 0; s_done = 0;
    s_psi = 0; s_psw = 0; s_isi = 0; s_isw = 0; s_rto = 0;
    m_owner = 0; m_resp = 0; m_to = 0; m_last = 0; m_pscnt = 0; m_iscnt = 0;
    drive(1'b0);

    phase = "reset";
    do_reset();
    tick();

    phase = "ps_only";
    s_psi = 10; s_psw = 3; s_pse = 1;
    do_reset();
    run_slots(25);

    phase = "both_sched";
    s_psi = 8; s_psw = 4; s_isi = 8; s_isw = 6; s_pse = 1; s_ise = 1;
    do_reset();
    run_slots(20);

    phase = "ps_hit_done";
    s_psi = 10; s_psw = 3; s_ise = 0;
    do_reset();
    wait_grant(1, "ps");
    repeat (SLOT + 1) tick();
    s_ps_hit = 1; tick();
    run_slots(2);
    s_done = 1; tick();
    run_slots(12);

    phase = "is_timeout4";
    s_pse = 0; s_ise = 1; s_isi = 8; s_isw = 6; s_rto = 4;
    do_reset();
    wait_grant(2, "is4");
    tick();
    s_is_hit = 1; tick();
    run_slots(7);

    phase = "is_timeout8";
    s_rto = 0;
    wait_grant(2, "is8");
    s_is_hit = 1; tick();
    run_slots(11);

    phase = "ignore_drop";
    s_pse = 1; s_ise = 1; s_psi = 8; s_psw = 4; s_isi = 8; s_isw = 6; s_rto = 3;
    do_reset();
    wait_grant(1, "ps_drop");
    tick(); tick();
    s_is_hit = 1; tick();
    run_slots(1);
    s_pse = 0; tick(); tick(); tick();
    s_pse = 1;
    run_slots(10);

    phase = "rst_in_resp";
    wait_grant(1, "ps_rst");
    s_ps_hit = 1; tick();
    tick();
    s_rst = 1; tick();
    s_rst = 0;
    run_slots(12);

    phase = "random";
    for (int i = 0; i < 1600; i++) begin
      if (i % 200 == 0) begin
        s_psi = $urandom_range(0, 12); s_psw = $urandom_range(0, 12);
        s_isi = $urandom_range(0, 12); s_isw = $urandom_range(0, 12);
        s_rto = $urandom_range(0, 15);
        s_pse = 1'($urandom_range(0, 1)); s_ise = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) == 0) s_pse = ~s_pse;
      if ($urandom_range(0, 99) == 0) s_ise = ~s_ise;
      s_ps_hit = ($urandom_range(0, 11) == 0);
      s_is_hit = ($urandom_range(0, 11) == 0);
      s_done   = ($urandom_range(0, 29) == 0);
      s_rst    = ($urandom_range(0, 499) == 0);
      tick();
      s_rst = 0;
    end

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
